// File: rtl/sqrt_core.sv
// sqrt_core: free-running restoring integer square root, one result bit per clock
module sqrt_core (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] din,
   output logic [15:0] dout,
   output logic [3:0]  cstate
);
   typedef enum logic [3:0] {IDLE = 4'd0, LOAD = 4'd1, CALC = 4'd2, DONE = 4'd3} state_t;
   state_t      state;
   logic [31:0] rad;
   logic [17:0] rem;
   logic [15:0] root;
   logic [3:0]  cnt;
   logic [17:0] t;
   logic [17:0] q;
   logic        ge;
   logic        rem_unused;
   assign t          = {rem[15:0], rad[31:30]};
   assign q          = {root, 2'b01};
   assign ge         = t >= q;
   assign cstate     = state;
   // the partial remainder never exceeds 16 bits before the last step, so its top bits are never fed back
   assign rem_unused = ^rem[17:16];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         dout  <= '0;
         rad   <= '0;
         rem   <= '0;
         root  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: state <= LOAD;
            LOAD: begin
               rad   <= din;
               rem   <= '0;
               root  <= '0;
               cnt   <= 4'd15;
               state <= CALC;
            end
            CALC: begin
               rem   <= ge ? t - q : t;
               root  <= {root[14:0], ge};
               rad   <= rad << 2;
               cnt   <= cnt - 4'd1;
               state <= cnt == 4'd0 ? DONE : CALC;
            end
            DONE: begin
               dout  <= root;
               state <= LOAD;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sqrt_core.sv
// tb_sqrt_core: self-checking bench for sqrt_core against a binary-search floor-sqrt model
module tb_sqrt_core;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] din = '0;
   logic [15:0] dout;
   logic [3:0]  cstate;
   int          checks = 0;
   int          failures = 0;

   sqrt_core dut (.clk(clk), .reset(reset), .din(din), .dout(dout), .cstate(cstate));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[11];

   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned lo = 0, hi = 65536, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= x) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart();
      reset = 1'b1;
      #1;
      chk("rst_dout", {16'd0, dout}, 0);
      chk("rst_state", {28'd0, cstate}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      vecs[0]  = '{32'd0, 16'd0};
      vecs[1]  = '{32'd1, 16'd1};
      vecs[2]  = '{32'd4, 16'd2};
      vecs[3]  = '{32'd1023, 16'd31};
      vecs[4]  = '{32'd1024, 16'd32};
      vecs[5]  = '{32'd65536, 16'd256};
      vecs[6]  = '{32'hFFFFFFFF, 16'hFFFF};
      vecs[7]  = '{32'hFFFE0001, 16'hFFFF};
      vecs[8]  = '{32'hFFFE0000, 16'hFFFE};
      vecs[9]  = '{32'd999, 16'd31};
      vecs[10] = '{32'd10000, 16'd100};

      tick(1);
      chk("reset_dout", {16'd0, dout}, 0);
      chk("reset_state", {28'd0, cstate}, 0);
      din = 32'd999;
      reset = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         tick(1);
         chk("seq_state", {28'd0, cstate}, k == 1 ? 1 : k <= 17 ? 2 : k == 18 ? 3 : 1);
         chk("seq_dout", {16'd0, dout}, k < 19 ? 0 : 31);
      end
      for (int k = 0; k < 36; k++) begin
         tick(1);
         chk("seq_stable", {16'd0, dout}, 31);
      end

      foreach (vecs[i]) begin
         din = vecs[i].din;
         restart();
         tick(18);
         chk("vec_latency", {16'd0, dout}, 0);
         tick(1);
         chk("vec_result", {16'd0, dout}, {16'd0, vecs[i].exp});
      end

      din = 32'd999;
      restart();
      tick(5);
      din = 32'd10000;
      tick(14);
      chk("midchg_first", {16'd0, dout}, 31);
      for (int k = 20; k <= 36; k++) begin
         tick(1);
         chk("midchg_hold", {16'd0, dout}, 31);
      end
      tick(1);
      chk("midchg_next", {16'd0, dout}, 100);

      tick(5);
      reset = 1'b1;
      #1;
      chk("async_dout", {16'd0, dout}, 0);
      chk("async_state", {28'd0, cstate}, 0);
      tick(2);
      chk("async_hold", {12'd0, cstate, dout}, 0);
      reset = 1'b0;
      tick(18);
      chk("async_done_state", {28'd0, cstate}, 3);
      chk("async_done_dout", {16'd0, dout}, 0);
      tick(1);
      chk("async_result", {16'd0, dout}, 100);
      chk("async_load", {28'd0, cstate}, 1);

      for (int n = 0; n < 1000; n++) begin
         for (int b = 0; b < 40 && cstate !== 4'd1; b++) tick(1);
         chk("rand_sync", {28'd0, cstate}, 1);
         v = $urandom >> $urandom_range(0, 31);
         din = v;
         tick(18);
         chk("rand_first", {16'd0, dout}, 32'(isqrt(64'(v))));
         tick(18);
         chk("rand_repeat", {16'd0, dout}, 32'(isqrt(64'(v))));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
